// File: rtl/reg_file_psr.sv
// Register file with processor-status register and a sequential clear FSM.
// Optional same-cycle write/flags bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_psr #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int FLAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flags_en,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  input  logic              clr_req,
  output logic [DATA_W-1:0] src_out,
  output logic [DATA_W-1:0] dest_out,
  output logic [FLAG_W-1:0] psr_out,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [FLAG_W-1:0]   psr_q;
  logic                wrAccept;

  // A clear request in the same cycle takes the slot, so the write is lost.
  assign wrAccept = wr_en && (state_q == IDLE) && !clr_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      regs_q[cnt_q] <= '0;
    end else if (wrAccept) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // The PSR survives clear sequences; only reset or flags_en change it.
  always_ff @(posedge clk) begin
    if (reset) begin
      psr_q <= '0;
    end else if (flags_en) begin
      psr_q <= flags_in;
    end
  end

  assign busy = (state_q == CLEAR);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    src_out  = regs_q[rd_addr_a];
    dest_out = regs_q[rd_addr_b];
    psr_out  = psr_q;
    if (wrAccept && (rd_addr_a == wr_addr)) begin
      src_out = wr_data;
    end
    if (wrAccept && (rd_addr_b == wr_addr)) begin
      dest_out = wr_data;
    end
    if (flags_en) begin
      psr_out = flags_in;
    end
  end
`else
  always_comb begin
    src_out  = regs_q[rd_addr_a];
    dest_out = regs_q[rd_addr_b];
    psr_out  = psr_q;
  end
`endif

endmodule

// File: tb/tb_reg_file_psr.sv
// Directed, table-driven bench for reg_file_psr with hand-computed expectations.
module tb_reg_file_psr;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        flags_en;
   logic [4:0]  flags_in;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;
   logic        clr_req;
   logic [15:0] src_out;
   logic [15:0] dest_out;
   logic [4:0]  psr_out;
   logic        busy;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      logic        wrEn;
      logic [3:0]  wrAddr;
      logic [15:0] wrData;
      logic        flagsEn;
      logic [4:0]  flagsIn;
      logic [3:0]  rdA;
      logic [3:0]  rdB;
      logic [15:0] expSrc;
      logic [15:0] expDest;
      logic [4:0]  expPsr;
   } vec_t;

   vec_t vecs [7];

   reg_file_psr dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .flags_en  (flags_en),
      .flags_in  (flags_in),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .clr_req   (clr_req),
      .src_out   (src_out),
      .dest_out  (dest_out),
      .psr_out   (psr_out),
      .busy      (busy)
   );

   // 10 ns clock; inputs change 1 ns after each rising edge
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and tally the result
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one table vector across a clock edge, then drop enables and check reads
   task automatic applyStimulus(input vec_t v, input int idx);
      wr_en     = v.wrEn;
      wr_addr   = v.wrAddr;
      wr_data   = v.wrData;
      flags_en  = v.flagsEn;
      flags_in  = v.flagsIn;
      rd_addr_a = v.rdA;
      rd_addr_b = v.rdB;
      tick();
      wr_en    = 1'b0;
      flags_en = 1'b0;
      #1;
      checkOutput($sformatf("vec%0d src", idx), 32'(src_out), 32'(v.expSrc));
      checkOutput($sformatf("vec%0d dest", idx), 32'(dest_out), 32'(v.expDest));
      checkOutput($sformatf("vec%0d psr", idx), 32'(psr_out), 32'(v.expPsr));
      checkOutput($sformatf("vec%0d busy", idx), 32'(busy), 32'd0);
   endtask

   task automatic writeReg(input logic [3:0] addr, input logic [15:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [3:0] addr, input logic [15:0] exp);
      rd_addr_a = addr;
      rd_addr_b = addr;
      #1;
      checkOutput($sformatf("%s r%0d src", name, addr), 32'(src_out), 32'(exp));
      checkOutput($sformatf("%s r%0d dest", name, addr), 32'(dest_out), 32'(exp));
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Main sequence: reset check, table vectors, then multi-cycle corner cases
   initial begin
      int busyCycles;
      int guard;
      logic [3:0] a;

      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      flags_en = 1'b0; flags_in = '0; rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;

      vecs[0] = '{1'b1, 4'd3,  16'h1234, 1'b0, 5'b00000, 4'd3,  4'd15, 16'h1234, 16'h0000, 5'h00};
      vecs[1] = '{1'b1, 4'd15, 16'hFFFF, 1'b0, 5'b00000, 4'd3,  4'd15, 16'h1234, 16'hFFFF, 5'h00};
      vecs[2] = '{1'b1, 4'd0,  16'h0001, 1'b1, 5'b10101, 4'd0,  4'd3,  16'h0001, 16'h1234, 5'h15};
      vecs[3] = '{1'b1, 4'd3,  16'h8000, 1'b0, 5'b00000, 4'd3,  4'd3,  16'h8000, 16'h8000, 5'h15};
      vecs[4] = '{1'b1, 4'd7,  16'h5A5A, 1'b1, 5'b00011, 4'd7,  4'd15, 16'h5A5A, 16'hFFFF, 5'h03};
      vecs[5] = '{1'b0, 4'd7,  16'hDEAD, 1'b0, 5'b11111, 4'd0,  4'd7,  16'h0001, 16'h5A5A, 5'h03};
      vecs[6] = '{1'b1, 4'd15, 16'h0000, 1'b0, 5'b00000, 4'd15, 4'd3,  16'h0000, 16'h8000, 5'h03};

      doReset();
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset psr", 32'(psr_out), 32'd0);
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         rd_addr_b = 4'(15 - i);
         #1;
         checkOutput($sformatf("reset src r%0d", i), 32'(src_out), 32'd0);
         checkOutput($sformatf("reset dest r%0d", 15 - i), 32'(dest_out), 32'd0);
      end

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Fill, load PSR, then clear with a same-cycle write that must lose
      doReset();
      for (int i = 0; i < 16; i++) begin
         writeReg(4'(i), 16'hA5A5);
      end
      readCheck("fill", 4'd9, 16'hA5A5);
      flags_en = 1'b1; flags_in = 5'b10101;
      tick();
      flags_en = 1'b0; flags_in = 5'b00000;
      clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h7777;
      tick();
      clr_req = 1'b0; wr_en = 1'b0;
      busyCycles = 0;
      guard = 0;
      while (busy && guard < 40) begin
         guard++;
         busyCycles++;
         if (psr_out !== 5'b10101) checkOutput("psr during clear", 32'(psr_out), 32'h15);
         clr_req = (busyCycles == 5);
         if (busyCycles == 11) begin
            wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0BAD;
         end
         tick();
         clr_req = 1'b0;
         wr_en = 1'b0;
      end
      checkOutput("clear busy cycles", 32'(busyCycles), 32'd16);
      checkOutput("busy after clear", 32'(busy), 32'd0);
      checkOutput("psr after clear", 32'(psr_out), 32'h15);
      for (int i = 0; i < 16; i++) begin
         readCheck("post-clear", 4'(i), 16'h0000);
      end
      writeReg(4'd9, 16'hCAFE);
      readCheck("write after clear", 4'd9, 16'hCAFE);

      // Reset in the fifth clear cycle aborts before the upper registers clear
      writeReg(4'd14, 16'hEEEE);
      writeReg(4'd15, 16'h0F0F);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checkOutput("busy at clear cycle 5", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("busy after abort", 32'(busy), 32'd0);
      checkOutput("psr after abort", 32'(psr_out), 32'd0);
      readCheck("abort", 4'd9, 16'h0000);
      readCheck("abort", 4'd14, 16'h0000);
      readCheck("abort", 4'd15, 16'h0000);

      // Same-cycle visibility of a write and of a flags load
      writeReg(4'd7, 16'h1111);
      writeReg(4'd3, 16'h3333);
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF;
      flags_en = 1'b1; flags_in = 5'b01010;
      rd_addr_a = 4'd7; rd_addr_b = 4'd3;
      #1;
`ifdef REGFILE_BYPASS_EN
      checkOutput("bypass src same cycle", 32'(src_out), 32'hBEEF);
      checkOutput("bypass psr same cycle", 32'(psr_out), 32'h0A);
`else
      checkOutput("no-bypass src same cycle", 32'(src_out), 32'h1111);
      checkOutput("no-bypass psr same cycle", 32'(psr_out), 32'h00);
`endif
      checkOutput("unmatched dest same cycle", 32'(dest_out), 32'h3333);
      tick();
      wr_en = 1'b0; flags_en = 1'b0;
      #1;
      checkOutput("src next cycle", 32'(src_out), 32'hBEEF);
      checkOutput("psr next cycle", 32'(psr_out), 32'h0A);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   // Hard stop so a stuck run still ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
